data_sram_responder: RTL and testbench

DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

---
 rtl/sram_resp_pkg.sv | 52 +++++
 rtl/byte_ram.sv | 27 ++
 rtl/data_sram_responder.sv | 124 ++++++++++++
 tb/tb_data_sram_responder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sram_resp_pkg.sv
// Shared MMIO map, register widths and small helpers for the data SRAM responder.
package sram_resp_pkg;

    localparam logic [15:0] MMIO_HI_DEFAULT = 16'hBFAF;

    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_COUNT   = 16'h0004;
    localparam logic [15:0] OFF_COMPARE = 16'h0008;
    localparam logic [15:0] OFF_STATUS  = 16'h000C;

    localparam int unsigned LED_W   = 16;
    localparam int unsigned COUNT_W = 32;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_LED,
        REG_COUNT,
        REG_COMPARE,
        REG_STATUS
    } mmio_reg_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_RAM,
        SRC_MMIO
    } rdata_src_e;

    // Byte-offset decode; the two low address bits never take part.
    function automatic mmio_reg_e decode_offset(input logic [15:0] off);
        mmio_reg_e r;
        case ({off[15:2], 2'b00})
            OFF_LED:     r = REG_LED;
            OFF_COUNT:   r = REG_COUNT;
            OFF_COMPARE: r = REG_COMPARE;
            OFF_STATUS:  r = REG_STATUS;
            default:     r = REG_NONE;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  wen);
        logic [31:0] r;
        r = old_w;
        for (int unsigned i = 0; i < 4; i++) begin
            if (wen[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/byte_ram.sv
// Single-port word RAM with byte-lane writes and registered read-before-write output.
module byte_ram #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic [3:0]        wen_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
            for (int unsigned i = 0; i < 4; i++) begin
                if (wen_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data-side memory responder: byte RAM plus an MMIO block with LED, free-running
// counter, compare/pending timer interrupt.
module data_sram_responder
    import sram_resp_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter logic [15:0] MMIO_HI = MMIO_HI_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic [5:0]  ext_int,
    output logic [15:0] led
);

    logic               mmio_sel;
    logic               ram_en;
    logic               wr;
    mmio_reg_e          reg_sel;
    logic [31:0]        ram_rdata;
    logic               pend_set;
    logic               pend_clr;
    logic [31:0]        led_merged;
    logic               unused_addr_lsb;

    logic [LED_W-1:0]   led_q,     led_d;
    logic [COUNT_W-1:0] count_q,   count_d;
    logic [COUNT_W-1:0] compare_q, compare_d;
    logic               pending_q, pending_d;
    logic [31:0]        mmio_rdata_q, mmio_rdata_d;
    rdata_src_e         src_q,     src_d;

    assign unused_addr_lsb = ^mem_addr[1:0];

    assign mmio_sel = mem_en && (mem_addr[31:16] == MMIO_HI);
    assign wr       = |mem_wen;
    assign reg_sel  = decode_offset(mem_addr[15:0]);
    // Gating with rst drops any RAM write that is in flight when reset asserts.
    assign ram_en   = mem_en && !mmio_sel && rst;

    byte_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk_i   (clk),
        .en_i    (ram_en),
        .wen_i   (mem_wen),
        .addr_i  (mem_addr[ADDR_W+1:2]),
        .wdata_i (mem_wdata),
        .rdata_o (ram_rdata)
    );

    assign led_merged = merge_lanes({{(32-LED_W){1'b0}}, led_q}, mem_wdata, mem_wen);

    always_comb begin
        led_d        = led_q;
        count_d      = count_q + 1'b1;
        compare_d    = compare_q;
        mmio_rdata_d = mmio_rdata_q;
        src_d        = src_q;
        pend_clr     = 1'b0;

        if (mem_en) src_d = mmio_sel ? SRC_MMIO : SRC_RAM;

        if (mmio_sel) begin
            case (reg_sel)
                REG_LED:     mmio_rdata_d = {{(32-LED_W){1'b0}}, led_q};
                REG_COUNT:   mmio_rdata_d = count_q;
                REG_COMPARE: mmio_rdata_d = compare_q;
                REG_STATUS:  mmio_rdata_d = {31'b0, pending_q};
                default:     mmio_rdata_d = '0;
            endcase
            if (wr) begin
                case (reg_sel)
                    REG_LED:     led_d     = led_merged[LED_W-1:0];
                    REG_COUNT:   count_d   = merge_lanes(count_q, mem_wdata, mem_wen);
                    REG_COMPARE: compare_d = merge_lanes(compare_q, mem_wdata, mem_wen);
                    REG_STATUS:  pend_clr  = mem_wen[0] && mem_wdata[0];
                    default:     ;
                endcase
            end
        end
    end

    // A match on the same edge as a STATUS clear keeps pending set.
    assign pend_set = (count_q == compare_q) && (compare_q != '0);

    always_comb begin
        pending_d = pending_q;
        if (pend_set)      pending_d = 1'b1;
        else if (pend_clr) pending_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q        <= '0;
            count_q      <= '0;
            compare_q    <= '0;
            pending_q    <= 1'b0;
            mmio_rdata_q <= '0;
            src_q        <= SRC_NONE;
        end else begin
            led_q        <= led_d;
            count_q      <= count_d;
            compare_q    <= compare_d;
            pending_q    <= pending_d;
            mmio_rdata_q <= mmio_rdata_d;
            src_q        <= src_d;
        end
    end

    always_comb begin
        case (src_q)
            SRC_RAM:  mem_rdata = ram_rdata;
            SRC_MMIO: mem_rdata = mmio_rdata_q;
            default:  mem_rdata = '0;
        endcase
    end

    assign ext_int = {pending_q, 5'b0};
    assign led     = led_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed self-checking bench for data_sram_responder.
module tb_data_sram_responder;

    localparam int unsigned ADDR_W = 12;
    localparam logic [31:0] MMIO   = 32'hBFAF_0000;

    logic        clk;
    logic        rst;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [5:0]  ext_int;
    logic [15:0] led;

    int errors = 0;
    int checks = 0;

    data_sram_responder #(.ADDR_W(ADDR_W), .MMIO_HI(16'hBFAF)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_en    (mem_en),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .ext_int   (ext_int),
        .led       (led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        mem_en    = 1'b1;
        mem_addr  = a;
        mem_wen   = w;
        mem_wdata = d;
        @(posedge clk);
        #1;
        mem_en  = 1'b0;
        mem_wen = 4'h0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_en = 1'b0; mem_wen = 4'h0; mem_addr = '0; mem_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (led !== 16'h0) begin errors++; $display("FAIL reset_led got=%h exp=0000", led); end
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=00000000", mem_rdata); end
        checks++; if (ext_int !== 6'h0) begin errors++; $display("FAIL reset_ext_int got=%b exp=000000", ext_int); end
        rst = 1'b1;
    endtask

    task automatic test_byte_lanes();
        access(32'h10, 4'hF, 32'h1122_3344);
        access(32'h10, 4'b0010, 32'h0000_AA00);
        access(32'h10, 4'h0, 32'h0);
        checks++; if (mem_rdata !== 32'h1122_AA44) begin errors++; $display("FAIL lane_read got=%h exp=1122aa44", mem_rdata); end
        idle();
        checks++; if (mem_rdata !== 32'h1122_AA44) begin errors++; $display("FAIL rdata_hold got=%h exp=1122aa44", mem_rdata); end
    endtask

    task automatic test_rbw_alias();
        access(32'h20, 4'hF, 32'hDEAD_BEEF);
        access(32'h20, 4'hF, 32'h0);
        checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rbw got=%h exp=deadbeef", mem_rdata); end
        access(32'h20 + (32'd4 << ADDR_W), 4'h0, 32'h0);
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL ram_alias got=%h exp=00000000", mem_rdata); end
    endtask

    task automatic test_timer();
        access(MMIO + 32'h8, 4'hF, 32'h40);
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL compare_pre got=%h exp=00000000", mem_rdata); end
        access(MMIO + 32'h4, 4'hF, 32'h3C);
        access(MMIO + 32'h4, 4'h0, 32'h0);
        checks++; if (mem_rdata !== 32'h3C) begin errors++; $display("FAIL count_written got=%h exp=0000003c", mem_rdata); end
        repeat (3) idle();
        checks++; if (ext_int !== 6'b000000) begin errors++; $display("FAIL int_early got=%b exp=000000", ext_int); end
        idle();
        checks++; if (ext_int !== 6'b100000) begin errors++; $display("FAIL int_set got=%b exp=100000", ext_int); end
        access(MMIO + 32'hC, 4'h0, 32'h0);
        checks++; if (mem_rdata !== 32'h1) begin errors++; $display("FAIL status_read got=%h exp=00000001", mem_rdata); end
        access(MMIO + 32'h8, 4'hF, 32'h1000);
        checks++; if (mem_rdata !== 32'h40) begin errors++; $display("FAIL compare_rbw got=%h exp=00000040", mem_rdata); end
        checks++; if (ext_int !== 6'b100000) begin errors++; $display("FAIL compare_keeps_pending got=%b exp=100000", ext_int); end
        access(MMIO + 32'hC, 4'h1, 32'h1);
        checks++; if (mem_rdata !== 32'h1) begin errors++; $display("FAIL status_rbw got=%h exp=00000001", mem_rdata); end
        checks++; if (ext_int !== 6'b000000) begin errors++; $display("FAIL int_clear got=%b exp=000000", ext_int); end
    endtask

    task automatic test_wrap_set_wins();
        access(MMIO + 32'h8, 4'hF, 32'h1);
        access(MMIO + 32'h4, 4'hF, 32'hFFFF_FFFE);
        idle();
        access(MMIO + 32'h4, 4'h0, 32'h0);
        checks++; if (mem_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_ffffffff got=%h exp=ffffffff", mem_rdata); end
        access(MMIO + 32'h4, 4'h0, 32'h0);
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL wrap_zero got=%h exp=00000000", mem_rdata); end
        access(MMIO + 32'h4, 4'h0, 32'h0);
        checks++; if (mem_rdata !== 32'h1) begin errors++; $display("FAIL wrap_one got=%h exp=00000001", mem_rdata); end
        checks++; if (ext_int !== 6'b100000) begin errors++; $display("FAIL wrap_pending got=%b exp=100000", ext_int); end
        access(MMIO + 32'hC, 4'h1, 32'h1);
        checks++; if (ext_int !== 6'b000000) begin errors++; $display("FAIL wrap_clear got=%b exp=000000", ext_int); end
        access(MMIO + 32'h4, 4'hF, 32'h0);
        idle();
        access(MMIO + 32'hC, 4'h1, 32'h1);
        checks++; if (ext_int !== 6'b100000) begin errors++; $display("FAIL set_wins got=%b exp=100000", ext_int); end
    endtask

    task automatic test_mmio_misc();
        access(MMIO + 32'h0, 4'h3, 32'hFFFF_1234);
        checks++; if (led !== 16'h1234) begin errors++; $display("FAIL led_write got=%h exp=1234", led); end
        access(MMIO + 32'h0, 4'h0, 32'h0);
        checks++; if (mem_rdata !== 32'h0000_1234) begin errors++; $display("FAIL led_read got=%h exp=00001234", mem_rdata); end
        access(MMIO + 32'h0, 4'b0010, 32'h0000_AB00);
        checks++; if (led !== 16'hAB34) begin errors++; $display("FAIL led_lane got=%h exp=ab34", led); end
        access(MMIO + 32'h10, 4'hF, 32'hFFFF_FFFF);
        access(MMIO + 32'h10, 4'h0, 32'h0);
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL unmapped got=%h exp=00000000", mem_rdata); end
    endtask

    task automatic test_async_reset();
        access(32'h10, 4'h0, 32'h0);
        checks++; if (mem_rdata !== 32'h1122_AA44) begin errors++; $display("FAIL pre_reset_read got=%h exp=1122aa44", mem_rdata); end
        mem_en = 1'b1; mem_addr = 32'h10; mem_wen = 4'hF; mem_wdata = 32'hCAFE_F00D;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (led !== 16'h0) begin errors++; $display("FAIL async_led got=%h exp=0000", led); end
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL async_rdata got=%h exp=00000000", mem_rdata); end
        checks++; if (ext_int !== 6'h0) begin errors++; $display("FAIL async_ext_int got=%b exp=000000", ext_int); end
        @(posedge clk);
        #1;
        mem_en = 1'b0; mem_wen = 4'h0;
        rst = 1'b1;
        access(MMIO + 32'h4, 4'h0, 32'h0);
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL release_count got=%h exp=00000000", mem_rdata); end
        access(32'h10, 4'h0, 32'h0);
        checks++; if (mem_rdata !== 32'h1122_AA44) begin errors++; $display("FAIL ram_kept got=%h exp=1122aa44", mem_rdata); end
    endtask

    initial begin
        test_reset();
        test_byte_lanes();
        test_rbw_alias();
        test_timer();
        test_wrap_set_wins();
        test_mmio_misc();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
